// File: rtl/hawk_axi_line_master.sv
// hawk_axi_line_master: turns single 64B line requests into 2-beat INCR
// AXI4 bursts, one transaction in flight, with a hung-slave watchdog.
module hawk_axi_line_master #(
    parameter int DATA_W  = 256,
    parameter int ID_W    = 6,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [ID_W-1:0]         req_id,
    input  logic [2*DATA_W-1:0]     req_wdata,
    input  logic [2*DATA_W/8-1:0]   req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_we,
    output logic [ID_W-1:0]         rsp_id,
    output logic [2*DATA_W-1:0]     rsp_rdata,
    output logic                    rsp_err,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [ID_W-1:0]         axi_awid,
    output logic [ADDR_W-1:0]       axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic [2:0]              axi_awsize,
    output logic [1:0]              axi_awburst,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    output logic [DATA_W-1:0]       axi_wdata,
    output logic [DATA_W/8-1:0]     axi_wstrb,
    output logic                    axi_wlast,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    input  logic [ID_W-1:0]         axi_bid,
    input  logic [1:0]              axi_bresp,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    output logic [ID_W-1:0]         axi_arid,
    output logic [ADDR_W-1:0]       axi_araddr,
    output logic [7:0]              axi_arlen,
    output logic [2:0]              axi_arsize,
    output logic [1:0]              axi_arburst,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,
    input  logic [ID_W-1:0]         axi_rid,
    input  logic [DATA_W-1:0]       axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LINE_W = 2 * DATA_W;
    localparam int SIZE   = $clog2(STRB_W);
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, RSP
    } state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [2*STRB_W-1:0] wstrb_q;
    logic [LINE_W-1:0]   rdata_q;
    logic                err_q;
    logic                cnt_q;
    logic [WD_W-1:0]     wd_q;

    logic active, expired, tmo;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic unused_addr_bits;

    assign unused_addr_bits = ^req_addr[5:0];

    assign active = (state_q != IDLE) && (state_q != RSP);
    assign expired = (TIMEOUT != 0) && active && (wd_q == WD_LAST);

    assign aw_hs = (state_q == WR_AW) && axi_awready;
    assign w_hs  = (state_q == WR_W)  && axi_wready;
    assign b_hs  = (state_q == WR_B)  && axi_bvalid;
    assign ar_hs = (state_q == RD_AR) && axi_arready;
    assign r_hs  = (state_q == RD_R)  && axi_rvalid;

    always_comb begin
        state_d = state_q;
        tmo     = 1'b0;
        unique case (state_q)
            IDLE:  if (req_valid) state_d = req_we ? WR_AW : RD_AR;
            WR_AW: if (aw_hs) state_d = WR_W;
                   else if (expired) begin state_d = RSP; tmo = 1'b1; end
            WR_W:  if (w_hs && cnt_q) state_d = WR_B;
                   else if (expired) begin state_d = RSP; tmo = 1'b1; end
            WR_B:  if (b_hs) state_d = RSP;
                   else if (expired) begin state_d = RSP; tmo = 1'b1; end
            RD_AR: if (ar_hs) state_d = RD_R;
                   else if (expired) begin state_d = RSP; tmo = 1'b1; end
            RD_R:  if (r_hs && cnt_q) state_d = RSP;
                   else if (expired) begin state_d = RSP; tmo = 1'b1; end
            RSP:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Watchdog restarts on every state change so each phase gets a full budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  wd_q <= '0;
        else if (state_d != state_q) wd_q <= '0;
        else if (active)             wd_q <= wd_q + WD_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                id_q    <= req_id;
                addr_q  <= {req_addr[ADDR_W-1:6], 6'd0};
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                rdata_q <= '0;
                err_q   <= 1'b0;
                cnt_q   <= 1'b0;
            end
            if (w_hs) cnt_q <= ~cnt_q;
            if (b_hs) begin
                err_q <= err_q | (axi_bresp != 2'b00) | (axi_bid != id_q);
            end
            if (r_hs) begin
                cnt_q <= ~cnt_q;
                if (cnt_q) rdata_q[LINE_W-1:DATA_W] <= axi_rdata;
                else       rdata_q[DATA_W-1:0]      <= axi_rdata;
                // rlast must be low on beat 0 and high on beat 1
                err_q <= err_q | (axi_rresp != 2'b00) | (axi_rid != id_q)
                       | (axi_rlast != cnt_q);
            end
            if (tmo) err_q <= 1'b1;
        end
    end

    assign req_ready = (state_q == IDLE);

    assign axi_awvalid = (state_q == WR_AW);
    assign axi_awid    = id_q;
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = 8'd1;
    assign axi_awsize  = 3'(SIZE);
    assign axi_awburst = 2'b01;

    assign axi_wvalid = (state_q == WR_W);
    assign axi_wdata  = cnt_q ? wdata_q[LINE_W-1:DATA_W] : wdata_q[DATA_W-1:0];
    assign axi_wstrb  = cnt_q ? wstrb_q[2*STRB_W-1:STRB_W] : wstrb_q[STRB_W-1:0];
    assign axi_wlast  = cnt_q;

    assign axi_bready = (state_q == WR_B);

    assign axi_arvalid = (state_q == RD_AR);
    assign axi_arid    = id_q;
    assign axi_araddr  = addr_q;
    assign axi_arlen   = 8'd1;
    assign axi_arsize  = 3'(SIZE);
    assign axi_arburst = 2'b01;

    assign axi_rready = (state_q == RD_R);

    assign rsp_valid = (state_q == RSP);
    assign rsp_we    = we_q;
    assign rsp_id    = id_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_hawk_axi_line_master.sv
// Bench for hawk_axi_line_master: table rows, stall/timeout/reset sequences
// and random traffic against a line-memory reference model.
module tb_hawk_axi_line_master;

    localparam int DW = 256;
    localparam int IW = 6;
    localparam int AW = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            req_valid, req_ready, req_we;
    logic [AW-1:0]   req_addr;
    logic [IW-1:0]   req_id;
    logic [2*DW-1:0] req_wdata;
    logic [63:0]     req_wstrb;
    logic            rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [IW-1:0]   rsp_id;
    logic [2*DW-1:0] rsp_rdata;
    logic            axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
    logic [IW-1:0]   axi_awid, axi_arid, axi_bid, axi_rid;
    logic [AW-1:0]   axi_awaddr, axi_araddr;
    logic [7:0]      axi_awlen, axi_arlen;
    logic [2:0]      axi_awsize, axi_arsize;
    logic [1:0]      axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic [DW-1:0]   axi_wdata, axi_rdata;
    logic [31:0]     axi_wstrb;
    logic            axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic            axi_rvalid, axi_rready, axi_rlast;

    hawk_axi_line_master #(.DATA_W(DW), .ID_W(IW), .ADDR_W(AW), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_id(req_id), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid),
        .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave knobs
    int aw_stall = 0, ar_stall = 0;
    bit w_rand = 0, r_rand = 0, no_b = 0, bid_flip = 0, early_last = 0, r_hold = 0;
    logic [1:0] bresp_v = 0, rresp0_v = 0;

    // Slave state and monitors
    logic [511:0] smem [logic [63:0]];
    logic [63:0]  s_addr, last_awaddr, last_araddr;
    logic [IW-1:0] s_id, last_awid, last_arid;
    logic [511:0] s_line;
    int  w_beat = 0, r_beat = 0, aw_wait = 0, ar_wait = 0;
    bit  b_pend = 0, r_act = 0, r_stuck = 0;
    int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0, rsp_rise = 0;
    int  attr_bad = 0, wlast_bad = 0, stab_bad = 0, bready_cyc = 0;
    bit  p_aw = 0, p_w = 0, p_ar = 0, p_rsp = 0;
    logic [63:0]  q_awaddr, q_araddr;
    logic [IW-1:0] q_awid, q_arid, q_rid;
    logic [DW-1:0] q_wdata;
    logic [31:0]  q_wstrb;
    logic         q_wlast, q_rwe, q_rerr;
    logic [511:0] q_rdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_arready = 0;
            axi_rvalid = 0; axi_bid = 0; axi_bresp = 0; axi_rid = 0;
            axi_rdata = 0; axi_rresp = 0; axi_rlast = 0;
            b_pend = 0; r_act = 0; r_beat = 0; w_beat = 0;
            aw_wait = 0; ar_wait = 0; r_stuck = 0;
            p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
        end else begin
            if (p_aw && (axi_awvalid !== 1'b1 || axi_awaddr !== q_awaddr || axi_awid !== q_awid))
                stab_bad++;
            if (p_w && (axi_wvalid !== 1'b1 || axi_wdata !== q_wdata ||
                        axi_wstrb !== q_wstrb || axi_wlast !== q_wlast))
                stab_bad++;
            if (p_ar && (axi_arvalid !== 1'b1 || axi_araddr !== q_araddr || axi_arid !== q_arid))
                stab_bad++;
            if (p_rsp && rsp_valid && (rsp_id !== q_rid || rsp_rdata !== q_rdata ||
                                       rsp_we !== q_rwe || rsp_err !== q_rerr))
                stab_bad++;
            if (rsp_valid && !p_rsp) rsp_rise++;

            axi_awready = axi_awvalid && (aw_wait >= aw_stall);
            if (axi_awvalid && !axi_awready) aw_wait++;
            axi_wready  = w_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi_bvalid  = b_pend && !no_b;
            axi_bid     = s_id ^ {5'd0, bid_flip};
            axi_bresp   = bresp_v;
            axi_arready = axi_arvalid && (ar_wait >= ar_stall);
            if (axi_arvalid && !axi_arready) ar_wait++;
            axi_rvalid  = r_act && !r_hold &&
                          (r_stuck || !r_rand || ($urandom_range(0, 3) != 0));
            axi_rid     = s_id;
            axi_rdata   = (r_beat == 0) ? s_line[255:0] : s_line[511:256];
            axi_rresp   = (r_beat == 0) ? rresp0_v : 2'b00;
            axi_rlast   = early_last ? (r_beat == 0) : (r_beat == 1);

            if (axi_awvalid && axi_awready) begin
                aw_cnt++; aw_wait = 0; w_beat = 0;
                s_addr = axi_awaddr; s_id = axi_awid;
                last_awaddr = axi_awaddr; last_awid = axi_awid;
                if (axi_awlen != 8'd1 || axi_awsize != 3'd5 || axi_awburst != 2'b01)
                    attr_bad++;
            end
            if (axi_wvalid && axi_wready) begin
                logic [511:0] ln;
                w_cnt++;
                if (axi_wlast !== (w_beat == 1)) wlast_bad++;
                ln = smem.exists(s_addr) ? smem[s_addr] : '0;
                for (int b = 0; b < 32; b++)
                    if (axi_wstrb[b]) ln[w_beat*256 + b*8 +: 8] = axi_wdata[b*8 +: 8];
                smem[s_addr] = ln;
                w_beat++;
                if (w_beat == 2) b_pend = 1;
            end
            if (axi_bvalid && axi_bready) begin
                b_cnt++; b_pend = 0;
            end
            if (axi_bready) bready_cyc++;
            if (axi_arvalid && axi_arready) begin
                ar_cnt++; ar_wait = 0;
                s_addr = axi_araddr; s_id = axi_arid;
                last_araddr = axi_araddr; last_arid = axi_arid;
                s_line = smem.exists(axi_araddr) ? smem[axi_araddr] : '0;
                r_act = 1; r_beat = 0;
                if (axi_arlen != 8'd1 || axi_arsize != 3'd5 || axi_arburst != 2'b01)
                    attr_bad++;
            end
            r_stuck = axi_rvalid && !axi_rready;
            if (axi_rvalid && axi_rready) begin
                r_cnt++; r_beat++;
                if (r_beat == 2) r_act = 0;
            end

            p_aw = axi_awvalid && !axi_awready;
            q_awaddr = axi_awaddr; q_awid = axi_awid;
            p_w = axi_wvalid && !axi_wready;
            q_wdata = axi_wdata; q_wstrb = axi_wstrb; q_wlast = axi_wlast;
            p_ar = axi_arvalid && !axi_arready;
            q_araddr = axi_araddr; q_arid = axi_arid;
            p_rsp = rsp_valid;
            q_rid = rsp_id; q_rdata = rsp_rdata; q_rwe = rsp_we; q_rerr = rsp_err;
        end
    end

    // Reference model: byte-addressed line memory keyed by 64B-aligned address
    logic [511:0] model_mem [logic [63:0]];
    logic [511:0] last_rdata;

    function automatic logic [511:0] merge(input logic [511:0] old, input logic [511:0] d,
                                           input logic [63:0] s);
        logic [511:0] r;
        r = old;
        for (int b = 0; b < 64; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic run_txn(input bit we, input logic [63:0] addr, input logic [IW-1:0] id,
                           input logic [511:0] wd, input logic [63:0] ws, input bit exp_err,
                           input int hold, input string nm);
        logic [63:0]  la;
        logic [511:0] exp_rd;
        int n, aw0, w0, ar0, r0, rs0;
        la = {addr[63:6], 6'd0};
        if (we) begin
            model_mem[la] = merge(model_mem.exists(la) ? model_mem[la] : '0, wd, ws);
            exp_rd = '0;
        end else begin
            exp_rd = model_mem.exists(la) ? model_mem[la] : '0;
        end
        aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; r0 = r_cnt; rs0 = rsp_rise;
        req_valid = 1; req_we = we; req_addr = addr; req_id = id;
        req_wdata = wd; req_wstrb = ws;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 0;
        chk({nm, " accept"}, (n < 50), 1);
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        chk({nm, " rsp_valid"}, rsp_valid, 1);
        chk({nm, " rsp_we/id/err"}, {rsp_we, rsp_id, rsp_err}, {we, id, exp_err});
        chk({nm, " rsp_rdata"}, rsp_rdata, exp_rd);
        last_rdata = rsp_rdata;
        repeat (hold) @(negedge clk);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        repeat (2) @(negedge clk);
        chk({nm, " axi addr/id"}, we ? {last_awaddr, last_awid} : {last_araddr, last_arid},
            {la, id});
        chk({nm, " counts aw/w/ar/r/rsp"},
            {aw_cnt - aw0, w_cnt - w0, ar_cnt - ar0, r_cnt - r0, rsp_rise - rs0},
            we ? {32'd1, 32'd2, 32'd0, 32'd0, 32'd1} : {32'd0, 32'd0, 32'd1, 32'd2, 32'd1});
        chk({nm, " protocol"}, {stab_bad, attr_bad, wlast_bad}, '0);
    endtask

    typedef struct {
        bit           we;
        logic [63:0]  addr;
        logic [IW-1:0] id;
        logic [511:0] wd;
        logic [63:0]  ws;
        logic [1:0]   bresp;
        bit           bid_flip;
        logic [1:0]   rresp0;
        bit           early_last;
        bit           exp_err;
    } vec_t;

    vec_t tbl[10];
    logic [511:0] line1, pat2, pat3, pat4;
    logic [63:0]  all1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, b0, rs0, br0;
        logic [1:0] rb;
        rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_id = 0;
        req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        line1 = {{32{8'h5A}}, {32{8'hA5}}};
        pat2  = {16{32'hDEADBEEF}};
        pat3  = {64{8'h11}};
        pat4  = {8{64'h0123456789ABCDEF}};
        all1  = '1;

        repeat (3) @(negedge clk);
        chk("reset ctrl", {req_ready, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid,
                           axi_rready, rsp_valid, rsp_we, rsp_err}, 9'b1_0000_0000);
        chk("reset rsp fields", {rsp_id, rsp_rdata}, '0);
        rst_n = 1;

        tbl[0] = '{we:1, addr:64'h1040, id:6'd5,  wd:line1, ws:all1, bresp:0, bid_flip:0,
                   rresp0:0, early_last:0, exp_err:0};
        tbl[1] = '{we:0, addr:64'h1040, id:6'd6,  wd:'0, ws:'0, bresp:0, bid_flip:0,
                   rresp0:0, early_last:0, exp_err:0};
        tbl[2] = '{we:0, addr:64'h1040, id:6'd7,  wd:'0, ws:'0, bresp:0, bid_flip:0,
                   rresp0:2'b10, early_last:0, exp_err:1};
        tbl[3] = '{we:1, addr:64'h2080, id:6'd9,  wd:pat2, ws:all1, bresp:0, bid_flip:1,
                   rresp0:0, early_last:0, exp_err:1};
        tbl[4] = '{we:0, addr:64'h2080, id:6'd10, wd:'0, ws:'0, bresp:0, bid_flip:0,
                   rresp0:0, early_last:1, exp_err:1};
        tbl[5] = '{we:1, addr:64'h107F, id:6'd11, wd:pat3, ws:64'h0000_FFFF_0000_00F0,
                   bresp:2'b10, bid_flip:0, rresp0:0, early_last:0, exp_err:1};
        tbl[6] = '{we:0, addr:64'h1040, id:6'd12, wd:'0, ws:'0, bresp:0, bid_flip:0,
                   rresp0:0, early_last:0, exp_err:0};
        tbl[7] = '{we:1, addr:64'h3000, id:6'd63, wd:pat4, ws:64'hF0F0_F0F0_0F0F_0F0F,
                   bresp:0, bid_flip:0, rresp0:0, early_last:0, exp_err:0};
        tbl[8] = '{we:0, addr:64'h3000, id:6'd0,  wd:'0, ws:'0, bresp:0, bid_flip:0,
                   rresp0:0, early_last:0, exp_err:0};
        tbl[9] = '{we:0, addr:64'h5000, id:6'd1,  wd:'0, ws:'0, bresp:0, bid_flip:0,
                   rresp0:0, early_last:0, exp_err:0};

        for (int i = 0; i < 10; i++) begin
            bresp_v = tbl[i].bresp; bid_flip = tbl[i].bid_flip;
            rresp0_v = tbl[i].rresp0; early_last = tbl[i].early_last;
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].id, tbl[i].wd, tbl[i].ws,
                    tbl[i].exp_err, i % 3, $sformatf("row%0d", i));
            if (i == 1) chk("row1 literal line", last_rdata, line1);
        end
        bresp_v = 0; bid_flip = 0; rresp0_v = 0; early_last = 0;

        aw_stall = 5; w_rand = 1;
        run_txn(1, 64'h4000, 6'd21, pat4 ^ line1, all1, 0, 2, "stall_wr");
        ar_stall = 3; r_rand = 1;
        run_txn(0, 64'h4000, 6'd22, '0, '0, 0, 1, "stall_rd");

        for (int i = 0; i < 30; i++) begin
            logic [511:0] wd;
            logic [63:0]  ws;
            bit we;
            for (int k = 0; k < 16; k++) wd[k*32 +: 32] = $urandom;
            ws = {$urandom, $urandom};
            we = $urandom_range(0, 1);
            rb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bresp_v = we ? rb : 2'b00;
            rresp0_v = we ? 2'b00 : rb;
            aw_stall = $urandom_range(0, 4); ar_stall = $urandom_range(0, 4);
            w_rand = $urandom_range(0, 1); r_rand = $urandom_range(0, 1);
            run_txn(we, 64'h8000 + 64'($urandom_range(0, 3) << 6) + 64'($urandom_range(0, 63)),
                    6'($urandom), wd, ws, (rb != 0), $urandom_range(0, 3),
                    $sformatf("rnd%0d", i));
        end
        aw_stall = 0; ar_stall = 0; w_rand = 0; r_rand = 0; bresp_v = 0; rresp0_v = 0;

        no_b = 1;
        br0 = bready_cyc;
        run_txn(1, 64'h6000, 6'd40, pat2, all1, 1, 0, "timeout_wr");
        chk("timeout bready cycles", bready_cyc - br0, 16);
        b0 = b_cnt;
        no_b = 0;
        repeat (4) @(negedge clk);
        chk("stray bvalid ignored", {b_cnt - b0, axi_bready, req_ready}, {32'd0, 1'b0, 1'b1});
        b_pend = 0;
        @(negedge clk);
        run_txn(0, 64'h6000, 6'd41, '0, '0, 0, 0, "after_timeout_rd");

        r_hold = 1;
        req_valid = 1; req_we = 0; req_addr = 64'h1040; req_id = 6'd33;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!axi_rready && n < 50) begin @(negedge clk); n++; end
        chk("rst reached RD_R", axi_rready, 1);
        rs0 = rsp_rise;
        #2 rst_n = 0;
        #1;
        chk("rst async ctrl", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid,
                               axi_bready, rsp_valid, rsp_we, rsp_err, rsp_id}, '0);
        chk("rst async rdata/req_ready", {rsp_rdata, req_ready}, 513'd1);
        r_hold = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (10) @(negedge clk);
        chk("rst no rsp", {rsp_rise - rs0, req_ready}, {32'd0, 1'b1});
        run_txn(0, 64'h2080, 6'd34, '0, '0, 0, 0, "after_reset_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
